mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit holding the architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of the register file: consumes the RD1/RD2 operand pair on start and produces HI/LO for MFHI/MFLO writeback through WD3.
- Radix-2, one bit per cycle, fixed latency; the core stalls on busy.

Parameters:
- WIDTH, 32, operand width and width of HI and LO.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  WIDTH  operand A (RD1): multiplicand or dividend
- src_b  input  WIDTH  operand B (RD2): multiplier or divisor
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse: HI/LO updated
- hi  output  WIDTH  HI register (MULT upper product; DIV remainder)
- lo  output  WIDTH  LO register (MULT lower product; DIV quotient)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, hi=0, lo=0, busy=0, done=0, counter and working registers 0. Reset mid-operation aborts the operation; no partial result is written.
- States: IDLE, CALC, FIX.
- IDLE: start=1 at edge E0 latches op, the operand magnitudes (absolute value for MULT/DIV, raw for MULTU/DIVU) and the result sign flags. Transition to CALC, counter=0, busy=1.
- CALC: one shift-add (multiply) or one restoring subtract-shift (divide) step per edge, counter+1. After WIDTH steps (edges E1..E_WIDTH) transition to FIX.
- FIX (edge E_WIDTH+1):
  - Apply sign correction: product negated if the operand signs differ; quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - Write hi/lo, done=1 for exactly that cycle, busy=0, state IDLE.
- Latency: WIDTH+1 edges from the accepting edge to the HI/LO update. The next start is accepted at edge E_WIDTH+2 at the earliest.
- Multiply result is the full 2*WIDTH product: hi = upper half, lo = lower half. Arithmetic uses WIDTH+1-bit internal adders; no truncation.
- Divide by zero: lo = all ones, hi = src_a (unsigned and signed). No exception.
- Signed overflow, e.g. 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- start while busy: ignored; no queueing.
- mthi/mtlo in IDLE: hi/lo <= wdata at the next edge.
- mthi/mtlo while busy: ignored.
- start and mthi/mtlo in the same IDLE cycle: start wins; the move is dropped.
- mthi and mtlo together: both registers written with wdata.
- hi/lo hold their previous values throughout CALC. They change only in FIX, on MTHI/MTLO, or on reset.
- Operands are captured at start. src_a/src_b may change freely afterwards.

Optional Feature:
- MDU_EARLY_TERM_EN defined: for MULT/MULTU, CALC exits to FIX as soon as the remaining unshifted multiplier bits are all zero. Results are identical; latency becomes variable, minimum 2 edges (multiplier 0 or 1). Divide latency is unchanged.
- Undefined: every operation takes exactly WIDTH+1 edges.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done pulses exactly 33 edges after the start edge; busy high for the 32 cycles in between.
- MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0x00000064 / 0x00000007 -> lo=0x0000000E, hi=0x00000002.
- DIVU 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Second start pulsed at cycle 5 of a MULT -> ignored; only one done is seen, with the first result. mthi=1, wdata=0xA5A5A5A5 while busy -> hi unchanged; the same stimulus in IDLE -> hi=0xA5A5A5A5 next edge.
- rst low at cycle 10 of a DIV -> hi=lo=0, busy=0 immediately. After release, a fresh MULTU 3 x 4 gives lo=0x0000000C, hi=0. With MDU_EARLY_TERM_EN defined, that MULTU completes in fewer than 33 edges.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, one bit per cycle,
// followed by a single sign-correction cycle that writes HI/LO.
// Optional build macro MDU_EARLY_TERM_EN: multiplies leave CALC once the remaining
// multiplier bits are all zero (same results, shorter variable latency).
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             is_div_q;
  logic             neg_res_q;  // negate product / quotient
  logic             neg_rem_q;  // negate remainder (dividend was negative)
  logic [WIDTH-1:0] mcand_q;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_q;      // product upper half or partial remainder
  logic [WIDTH-1:0] sh_q;       // multiplier/product low half or dividend/quotient
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;
`ifdef MDU_EARLY_TERM_EN
  logic [WIDTH-1:0] mplr_q;     // multiplier bits not yet consumed
`endif

  // Operand conditioning: magnitudes and sign flags for the signed ops.
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  always_comb begin
    sign_a = ~op[0] & src_a[WIDTH-1];
    sign_b = ~op[0] & src_b[WIDTH-1];
    mag_a  = sign_a ? -src_a : src_a;
    mag_b  = sign_b ? -src_b : src_b;
  end

  // One iteration step: shift-add for multiply, restoring subtract-shift for divide.
  logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_step, sh_step;
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh   = {acc_q, sh_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mcand_q};
    // Partial remainder stays below twice the divisor, so bit WIDTH is a valid sign.
    div_ge   = ~rem_diff[WIDTH];
    if (is_div_q) begin
      acc_step = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      sh_step  = {sh_q[WIDTH-2:0], div_ge};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      sh_step  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // Early-exit decision for multiplies.
  logic early_exit;
`ifdef MDU_EARLY_TERM_EN
  always_comb begin
    early_exit = ~is_div_q & (mplr_q[WIDTH-1:1] == '0);
  end
`else
  always_comb begin
    early_exit = 1'b0;
  end
`endif

  // Sign correction of the finished product, quotient and remainder.
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
`ifdef MDU_EARLY_TERM_EN
  logic [CntW-1:0]    shamt;
`endif
  always_comb begin
`ifdef MDU_EARLY_TERM_EN
    // After an early exit the product still sits WIDTH-cnt bits too far left.
    shamt    = CntW'(WIDTH) - cnt_q;
    prod_raw = {acc_q, sh_q} >> shamt;
`else
    prod_raw = {acc_q, sh_q};
`endif
    prod_fix = neg_res_q ? -prod_raw : prod_raw;
    quo_fix  = neg_res_q ? -sh_q : sh_q;
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
  end

  // Control FSM, datapath registers and architectural HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MDU_EARLY_TERM_EN
      mplr_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // start wins over a simultaneous MTHI/MTLO
            is_div_q  <= op[1];
            mcand_q   <= op[1] ? mag_b : mag_a;
            sh_q      <= op[1] ? mag_a : mag_b;
            acc_q     <= '0;
            // Divide by zero keeps the all-ones quotient unnegated.
            neg_res_q <= (sign_a ^ sign_b) & ~(op[1] & (src_b == '0));
            neg_rem_q <= sign_a;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StCalc;
`ifdef MDU_EARLY_TERM_EN
            mplr_q    <= mag_b;
`endif
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          sh_q  <= sh_step;
          cnt_q <= cnt_q + CntW'(1);
`ifdef MDU_EARLY_TERM_EN
          mplr_q <= mplr_q >> 1;
`endif
          if (cnt_q == LastCnt || early_exit) state_q <= StFix;
        end
        StFix: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, randomized operations
// against a plain-arithmetic reference model, busy/move/reset corner cases.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks;
  int failures;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain 64-bit / integer arithmetic.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, b,
                                    output logic [31:0] rh, output logic [31:0] rl);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        rh = sp[63:32];
        rl = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        rh = up[63:32];
        rl = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          rl = 32'hFFFF_FFFF;
          rh = a;
        end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000;
          rh = 32'd0;
        end else if (o == 2'b10) begin
          rl = sa / sb;
          rh = sa % sb;
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
    endcase
  endfunction

  // Expected edges from the start edge to done.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    logic [31:0] m;
    int          steps;
    m     = (!o[0] && b[31]) ? -b : b;
    steps = 1;
    for (int i = 0; i < 32; i++) if (m[i]) steps = i + 1;
`ifdef MDU_EARLY_TERM_EN
    return o[1] ? 33 : steps + 1;
`else
    return (steps > 0) ? 33 : 33;
`endif
  endfunction

  // Launch one operation from IDLE and collect result, latency and protocol errors.
  // Called at posedge+1 with the unit idle; returns at posedge+1 with the unit idle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int lat, output int bad);
    logic [31:0] h0, l0;
    h0    = hi;
    l0    = lo;
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    op    = 2'($urandom);
    bad   = 0;
    lat   = 0;
    if (busy !== 1'b1) bad++;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1 || hi !== h0 || lo !== l0) bad++;
    end
    rh = hi;
    rl = lo;
    if (busy !== 1'b0) bad++;
    @(posedge clk); #1;
    if (done !== 1'b0) bad++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b hi=%h lo=%h exp all 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [8];
    logic [31:0] t_a [8], t_b [8], t_hi [8], t_lo [8];
    logic [31:0] rh, rl;
    int          lat, bad;
    t_op = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
    t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0000_0064,
             32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFF9, 32'h0000_0007};
    t_b  = '{32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0002, 32'h0000_0007,
             32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFE};
    t_hi = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002,
             32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001};
    t_lo = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'h0000_000E,
             32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], rh, rl, lat, bad);
      checks++;
      if (rh !== t_hi[i]) begin
        failures++; $display("FAIL directed%0d_hi got=%h exp=%h", i, rh, t_hi[i]);
      end
      checks++;
      if (rl !== t_lo[i]) begin
        failures++; $display("FAIL directed%0d_lo got=%h exp=%h", i, rl, t_lo[i]);
      end
      checks++;
      if (lat !== exp_lat(t_op[i], t_b[i])) begin
        failures++;
        $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, exp_lat(t_op[i], t_b[i]));
      end
      checks++;
      if (bad !== 0) begin
        failures++; $display("FAIL directed%0d_busy_hold got=%0d errors exp=0", i, bad);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, eh, el, rh, rl;
    int          lat, bad, mode;
    for (int i = 0; i < 40; i++) begin
      o    = 2'($urandom);
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 5);
      if (mode == 0) b = 32'd0;
      else if (mode == 1) b = 32'($urandom_range(0, 300));
      else if (mode == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 3) b = -32'($urandom_range(1, 300));
      ref_model(o, a, b, eh, el);
      run_op(o, a, b, rh, rl, lat, bad);
      checks++;
      if (rh !== eh || rl !== el) begin
        failures++;
        $display("FAIL random%0d op=%b a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h",
                 i, o, a, b, rh, rl, eh, el);
      end
      checks++;
      if (lat !== exp_lat(o, b) || bad !== 0) begin
        failures++;
        $display("FAIL random%0d_timing got lat=%0d errors=%0d exp lat=%0d errors=0",
                 i, lat, bad, exp_lat(o, b));
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] a, b, eh, el, rh, rl;
    int          dones;
    a = $urandom;
    b = {2'b01, 30'($urandom)};
    ref_model(2'b00, a, b, eh, el);
    op    = 2'b00;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    rh    = '0;
    rl    = '0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 5) begin
        start = 1'b1;
        op    = 2'b11;
        src_a = $urandom;
        src_b = 32'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        rh = hi;
        rl = lo;
      end
    end
    checks++;
    if (dones !== 1) begin failures++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
    checks++;
    if (rh !== eh || rl !== el) begin
      failures++;
      $display("FAIL busy_start_result got hi=%h lo=%h exp hi=%h lo=%h", rh, rl, eh, el);
    end
  endtask

  task automatic test_move();
    logic [31:0] h0, l0, w, a, b, eh, el;
    int          seen;
    // Move while busy is ignored.
    h0    = hi;
    l0    = lo;
    op    = 2'b11;
    src_a = 32'd1000;
    src_b = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    checks++;
    if (hi !== h0 || lo !== l0) begin
      failures++;
      $display("FAIL move_busy got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, h0, l0);
    end
    seen = 0;
    for (int n = 0; n < 60 && seen == 0; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (seen !== 1 || hi !== 32'd6 || lo !== 32'd142) begin
      failures++;
      $display("FAIL move_busy_result got done=%0d hi=%h lo=%h exp done=1 hi=6 lo=8e",
               seen, hi, lo);
    end
    @(posedge clk); #1;
    // MTHI in IDLE.
    l0    = lo;
    mthi  = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    mthi = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== l0) begin
      failures++;
      $display("FAIL mthi_idle got hi=%h lo=%h exp hi=a5a5a5a5 lo=%h", hi, lo, l0);
    end
    // MTLO in IDLE.
    w     = $urandom;
    mtlo  = 1'b1;
    wdata = w;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++;
    if (lo !== w || hi !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL mtlo_idle got hi=%h lo=%h exp hi=a5a5a5a5 lo=%h", hi, lo, w);
    end
    // Both together.
    w     = $urandom;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = w;
    @(posedge clk); #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    checks++;
    if (hi !== w || lo !== w) begin
      failures++; $display("FAIL mthi_mtlo got hi=%h lo=%h exp both=%h", hi, lo, w);
    end
    // start and mthi together: start wins.
    a = $urandom;
    b = $urandom;
    ref_model(2'b01, a, b, eh, el);
    op    = 2'b01;
    src_a = a;
    src_b = b;
    start = 1'b1;
    mthi  = 1'b1;
    wdata = ~w;
    @(posedge clk); #1;
    start = 1'b0;
    mthi  = 1'b0;
    checks++;
    if (hi !== w || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_vs_mthi got hi=%h busy=%b exp hi=%h busy=1", hi, busy, w);
    end
    seen = 0;
    for (int n = 0; n < 60 && seen == 0; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (seen !== 1 || hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL start_vs_mthi_result got done=%0d hi=%h lo=%h exp done=1 hi=%h lo=%h",
               seen, hi, lo, eh, el);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rh, rl;
    int          lat, bad;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    op    = 2'b10;
    src_a = 32'hFFFF_FF00;
    src_b = 32'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_op got hi=%h lo=%h busy=%b done=%b exp all 0", hi, lo, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(2'b01, 32'd3, 32'd4, rh, rl, lat, bad);
    checks++;
    if (rh !== 32'd0 || rl !== 32'h0000_000C) begin
      failures++; $display("FAIL post_reset_multu got hi=%h lo=%h exp hi=0 lo=c", rh, rl);
    end
    checks++;
    if (lat !== exp_lat(2'b01, 32'd4) || bad !== 0) begin
      failures++;
      $display("FAIL post_reset_timing got lat=%0d errors=%0d exp lat=%0d errors=0",
               lat, bad, exp_lat(2'b01, 32'd4));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    src_a    = '0;
    src_b    = '0;
    mthi     = 1'b0;
    mtlo     = 1'b0;
    wdata    = '0;
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_move();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
